id_ex_stage: RTL

ID/EX pipeline stage of the five-stage MIPS datapath, directly upstream of the ALU. It registers decoded operands at the ID/EX boundary and decodes opcode/funct into the 4-bit ALU control code and EX/MEM/WB control bits. It resolves data hazards by forwarding from EX/MEM and MEM/WB and requests a load-use stall. It drives the ALU's `ALUctrlop`, `in0` and `in1` inputs.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/ex_ctrl_decode.sv | 81 ++++++++
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: opcode/funct encodings, ALU control codes
// and the EX/MEM/WB control bundle carried through the pipeline.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1000;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic branch;
    logic jump;
    logic alusrc;  // in1 takes the immediate instead of rt
  } ex_ctrl_t;

endpackage

// File: rtl/ex_ctrl_decode.sv
// Combinational opcode/funct decode into ALU control, pipeline control bits,
// destination select and the source-operand usage needed for hazard detection.
module ex_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctrlop_o,
  output ex_ctrl_t   ctrl_o,
  output logic       illegal_o,
  output logic       dest_rd_o,
  output logic       uses_rs_o,
  output logic       uses_rt_o
);

  always_comb begin
    ctrlop_o  = ALU_AND;
    ctrl_o    = '0;
    illegal_o = 1'b0;
    dest_rd_o = 1'b0;
    uses_rs_o = 1'b0;
    uses_rt_o = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.regwrite = 1'b1;
        dest_rd_o       = 1'b1;
        uses_rs_o       = 1'b1;
        uses_rt_o       = 1'b1;
        unique case (funct_i)
          FN_ADD:  ctrlop_o = ALU_ADD;
          FN_SUB:  ctrlop_o = ALU_SUB;
          FN_AND:  ctrlop_o = ALU_AND;
          FN_OR:   ctrlop_o = ALU_OR;
          FN_NOR:  ctrlop_o = ALU_NOR;
          FN_SLT:  ctrlop_o = ALU_SLT;
          default: begin
            // Unknown funct: behave like any other illegal instruction
            illegal_o = 1'b1;
            ctrl_o    = '0;
            dest_rd_o = 1'b0;
            uses_rs_o = 1'b0;
            uses_rt_o = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        ctrlop_o        = ALU_ADD;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        uses_rs_o       = 1'b1;
      end
      OP_LW: begin
        ctrlop_o        = ALU_ADD;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memread  = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        uses_rs_o       = 1'b1;
      end
      OP_SW: begin
        ctrlop_o        = ALU_ADD;
        ctrl_o.memwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        uses_rs_o       = 1'b1;
        uses_rt_o       = 1'b1;
      end
      OP_BEQ: begin
        ctrlop_o      = ALU_SUB;
        ctrl_o.branch = 1'b1;
        uses_rs_o     = 1'b1;
        uses_rt_o     = 1'b1;
      end
      OP_J: begin
        ctrlop_o    = ALU_ADD;
        ctrl_o.jump = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with control decode, EX/MEM and MEM/WB operand
// forwarding and load-use stall detection feeding the ALU.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          hold,
  input  logic          flush,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [3:0]    alu_ctrlop,
  output logic [DW-1:0] alu_in0,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_branch,
  output logic          ex_jump,
  output logic          ex_illegal,
  output logic [RW-1:0] ex_dest,
  output logic          hazard_stall
);

  logic [3:0] dec_ctrlop;
  ex_ctrl_t   dec_ctrl;
  logic       dec_illegal;
  logic       dec_dest_rd;
  logic       dec_uses_rs;
  logic       dec_uses_rt;

  ex_ctrl_decode u_decode (
    .opcode_i  (id_opcode),
    .funct_i   (id_funct),
    .ctrlop_o  (dec_ctrlop),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .dest_rd_o (dec_dest_rd),
    .uses_rs_o (dec_uses_rs),
    .uses_rt_o (dec_uses_rt)
  );

  logic          valid_q, valid_d;
  logic [3:0]    ctrlop_q, ctrlop_d;
  ex_ctrl_t      ctrl_q, ctrl_d;
  logic          illegal_q, illegal_d;
  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [RW-1:0] id_dest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrlop_q  <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      dest_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrlop_q  <= ctrlop_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      dest_q    <= dest_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  always_comb begin
    id_dest = '0;
    if (dec_dest_rd) id_dest = id_rd;
    else if (dec_ctrl.regwrite) id_dest = id_rt;
  end

  // Capture priority: flush, then hold, then load-use bubble, then load
  always_comb begin
    valid_d   = valid_q;
    ctrlop_d  = ctrlop_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    dest_d    = dest_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    if (flush || (!hold && hazard_stall)) begin
      valid_d   = 1'b0;
      ctrlop_d  = '0;
      ctrl_d    = '0;
      illegal_d = 1'b0;
      rs_d      = '0;
      rt_d      = '0;
      dest_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
    end else if (!hold) begin
      valid_d         = id_valid;
      ctrlop_d        = dec_ctrlop;
      ctrl_d          = dec_ctrl;
      ctrl_d.regwrite = dec_ctrl.regwrite && (id_dest != '0);
      illegal_d       = dec_illegal;
      rs_d            = id_rs;
      rt_d            = id_rt;
      dest_d          = id_dest;
      rs_data_d       = id_rs_data;
      rt_data_d       = id_rt_data;
      imm_d           = id_imm;
    end
  end

  function automatic logic [DW-1:0] fwd_sel(
    input logic [RW-1:0] idx,
    input logic [DW-1:0] reg_data,
    input logic          em_we,
    input logic [RW-1:0] em_rd,
    input logic [DW-1:0] em_res,
    input logic          mw_we,
    input logic [RW-1:0] mw_rd,
    input logic [DW-1:0] mw_res
  );
    if (em_we && (em_rd != '0) && (em_rd == idx)) return em_res;
    if (mw_we && (mw_rd != '0) && (mw_rd == idx)) return mw_res;
    return reg_data;
  endfunction

  logic [DW-1:0] fwd_rs, fwd_rt;

  always_comb begin
    fwd_rs = fwd_sel(rs_q, rs_data_q, exmem_regwrite, exmem_rd, exmem_result,
                     memwb_regwrite, memwb_rd, memwb_result);
    fwd_rt = fwd_sel(rt_q, rt_data_q, exmem_regwrite, exmem_rd, exmem_result,
                     memwb_regwrite, memwb_rd, memwb_result);
  end

  assign alu_ctrlop    = ctrlop_q;
  assign alu_in0       = fwd_rs;
  assign alu_in1       = ctrl_q.alusrc ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_valid      = valid_q;
  assign ex_regwrite   = ctrl_q.regwrite;
  assign ex_memread    = ctrl_q.memread;
  assign ex_memwrite   = ctrl_q.memwrite;
  assign ex_memtoreg   = ctrl_q.memtoreg;
  assign ex_branch     = ctrl_q.branch;
  assign ex_jump       = ctrl_q.jump;
  assign ex_illegal    = illegal_q;
  assign ex_dest       = dest_q;

  // Load in EX whose destination is a source of the instruction in ID
  assign hazard_stall = valid_q && ctrl_q.memread && (dest_q != '0) && id_valid &&
                        ((dec_uses_rs && (id_rs == dest_q)) ||
                         (dec_uses_rt && (id_rt == dest_q)));

endmodule
